if_neuron_layer: RTL and testbench
==================================

Name: if_neuron_layer

Overview:
Layer of NUM_OUTPUTS integrate-and-fire neurons. Each neuron accumulates signed weighted input spikes into a membrane potential, fires when the potential reaches THRESH, then holds a refractory period. spike_out feeds the layer controller, which returns neuron_rst to this block. This block is the stage directly upstream of the controller.

Parameters:
NUM_INPUTS, 4, number of presynaptic spike lines
NUM_OUTPUTS, 1, number of neurons
REFRAC, 5, refractory length in enabled steps (0 = none)
WEIGHT_W, 8, signed weight width
POT_W, 16, signed membrane potential width (POT_W >= WEIGHT_W + clog2(NUM_INPUTS))
THRESH, 64, signed firing threshold (must be > 0)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
step_en  in  1  time-step enable; state advances only when 1
spike_in  in  NUM_INPUTS  input spikes for this step
weights  in  NUM_INPUTS*NUM_OUTPUTS*WEIGHT_W  signed weights; w[i][j] = weights[(j*NUM_INPUTS+i)*WEIGHT_W +: WEIGHT_W]
neuron_rst  in  NUM_OUTPUTS  per-neuron reset from layer controller
spike_out  out  NUM_OUTPUTS  registered one-step fire pulse
potential  out  NUM_OUTPUTS*POT_W  registered membrane potentials, neuron j at [j*POT_W +: POT_W]

Behaviour:
- Per-neuron state: v_j (signed POT_W) and refractory counter r_j (clog2(REFRAC+1) bits, minimum 1).
- Priority at each rising edge, per neuron: rst > step_en==0 > neuron_rst[j] > r_j>0 > integrate.
- rst: v_j=0, r_j=0, spike_out=0. potential reads 0 on the cycle after the edge. rst applied during a refractory period clears it.
- step_en=0: v_j and r_j hold. spike_out forced 0. All inputs, including neuron_rst, are ignored.
- neuron_rst[j]=1 (step_en=1): v_j=0, r_j=REFRAC, spike_out[j]=0. This reloads r_j even if it is already nonzero.
- r_j>0: r_j decrements by 1. v_j stays 0. spike_in is ignored. spike_out[j]=0.
- Integrate:
  - sum = v_j + Σ over i with spike_in[i]=1 of sign-extended w[i][j].
  - Compute sum at POT_W+clog2(NUM_INPUTS)+1 bits, then saturate to [-2^(POT_W-1), 2^(POT_W-1)-1]. No wrap.
  - If sat_sum >= THRESH: spike_out[j]=1 for exactly one cycle, v_j=0, r_j=REFRAC.
  - Else: v_j=sat_sum, spike_out[j]=0.
- Latency: a spike_in that pushes a neuron over threshold at edge N gives spike_out high during cycle N+1 (one register stage).
- REFRAC=0: a neuron that fired at edge N integrates again at edge N+1.
- Neurons are fully independent. All neurons update in parallel in the same cycle.
- Closed loop with the controller (neuron_rst = spike_out):
  - A fire at edge N gives neuron_rst high in cycle N+1, which reloads r_j at edge N+1.
  - Integration resumes at edge N+REFRAC+2.
  - This extra step is intended.
- No combinational path from any input to any output.

Test Plan:
1. Reset: assert rst for 2 cycles with random spike_in/weights -> spike_out=0, all potential=0; first enabled step after release integrates from 0.
2. Integrate and fire (NUM_INPUTS=4, NUM_OUTPUTS=2, THRESH=64, REFRAC=5, neuron_rst=0): w[0][0]=20, spike_in=4'b0001 each step -> potential 20, 40, 60; 4th edge fires, spike_out[0] high 1 cycle, potential 0; next 5 steps potential stays 0; 10th edge potential=20. spike_out[1] stays 0.
3. Multi-input and negative weights: w[0][1]=30, w[1][1]=40, w[2][1]=-10, spike_in=4'b0111 -> 60, then 120>=64 fires on 2nd edge. Separately w[3][0]=-100, spike_in=4'b1000, POT_W=8 -> -100 then saturates at -128, holds at -128 (no wrap).
4. neuron_rst: potential[0]=40, pulse neuron_rst[0] one cycle -> potential 0, next 5 enabled steps ignore spikes. neuron_rst together with a threshold-crossing input -> no spike, potential 0.
5. step_en gating: step_en=0 for 10 cycles mid-refractory with spikes present -> potential and refractory frozen, spike_out=0. Resume -> remaining refractory steps complete exactly. rst mid-refractory -> next enabled step integrates immediately.
6. Closed loop with controller model (neuron_rst=spike_out), REFRAC=5: fire at edge N -> neuron_rst high cycle N+1, integration resumes at edge N+7. With REFRAC=0 -> resumes at edge N+2.

Source files
------------

// File: rtl/if_neuron_layer.sv
// if_neuron_layer: a layer of NUM_OUTPUTS integrate-and-fire neurons.
// Each neuron sums the signed weights of the active input spikes into its
// membrane potential. When the potential reaches THRESH the neuron fires,
// clears its potential, and is then refractory for REFRAC enabled steps.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   step_en    time-step enable; state advances only when 1
//   spike_in   [NUM_INPUTS]  input spikes for this step
//   weights    [NUM_INPUTS*NUM_OUTPUTS*WEIGHT_W] signed weights,
//              w[i][j] at (j*NUM_INPUTS+i)*WEIGHT_W
//   neuron_rst [NUM_OUTPUTS] per-neuron reset from the layer controller
//   spike_out  [NUM_OUTPUTS] registered one-step fire pulse
//   potential  [NUM_OUTPUTS*POT_W] registered potentials, neuron j at j*POT_W

// One neuron. Its weight bus holds w[0..NUM_INPUTS-1] for this neuron only.
module if_neuron #(
  parameter int NUM_INPUTS = 4,
  parameter int REFRAC     = 5,
  parameter int WEIGHT_W   = 8,
  parameter int POT_W      = 16,
  parameter int THRESH     = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           step_en,
  input  logic [NUM_INPUTS-1:0]          spike_in,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] w,
  input  logic                           neuron_rst,
  output logic                           spike,
  output logic [POT_W-1:0]               v
);
  // Wide enough that the sum of the old potential and every weight cannot
  // overflow before saturation.
  localparam int SW = POT_W + $clog2(NUM_INPUTS) + 1;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-POT_W+1){1'b0}}, {(POT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-POT_W+1){1'b1}}, {(POT_W-1){1'b0}}};
  localparam logic signed [POT_W-1:0] THRESH_V = POT_W'(THRESH);
  localparam logic [RW-1:0]           REFRAC_V = RW'(REFRAC);

  logic [RW-1:0]           r;
  logic signed [SW-1:0]    sum;
  logic signed [POT_W-1:0] sat;
  logic                    fire;

  always_comb begin
    sum = {{(SW-POT_W){v[POT_W-1]}}, v};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spike_in[i])
        sum = sum + {{(SW-WEIGHT_W){w[i*WEIGHT_W+WEIGHT_W-1]}},
                     w[i*WEIGHT_W +: WEIGHT_W]};
    end
    if (sum > SAT_MAX)      sat = SAT_MAX[POT_W-1:0];
    else if (sum < SAT_MIN) sat = SAT_MIN[POT_W-1:0];
    else                    sat = sum[POT_W-1:0];
    fire = (sat >= THRESH_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      r     <= '0;
      spike <= 1'b0;
    end else if (!step_en) begin
      // Frozen step: state holds, the pulse is not stretched.
      spike <= 1'b0;
    end else if (neuron_rst) begin
      v     <= '0;
      r     <= REFRAC_V;
      spike <= 1'b0;
    end else if (r != '0) begin
      v     <= '0;
      r     <= r - RW'(1);
      spike <= 1'b0;
    end else if (fire) begin
      v     <= '0;
      r     <= REFRAC_V;
      spike <= 1'b1;
    end else begin
      v     <= sat;
      spike <= 1'b0;
    end
  end
endmodule

module if_neuron_layer #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 1,
  parameter int REFRAC      = 5,
  parameter int WEIGHT_W    = 8,
  parameter int POT_W       = 16,
  parameter int THRESH      = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       step_en,
  input  logic [NUM_INPUTS-1:0]                      spike_in,
  input  logic [NUM_INPUTS*NUM_OUTPUTS*WEIGHT_W-1:0] weights,
  input  logic [NUM_OUTPUTS-1:0]                     neuron_rst,
  output logic [NUM_OUTPUTS-1:0]                     spike_out,
  output logic [NUM_OUTPUTS*POT_W-1:0]               potential
);
  localparam int WB = NUM_INPUTS * WEIGHT_W;

  for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_neuron
    if_neuron #(
      .NUM_INPUTS(NUM_INPUTS), .REFRAC(REFRAC), .WEIGHT_W(WEIGHT_W),
      .POT_W(POT_W), .THRESH(THRESH)
    ) u_neuron (
      .clk        (clk),
      .rst        (rst),
      .step_en    (step_en),
      .spike_in   (spike_in),
      .w          (weights[j*WB +: WB]),
      .neuron_rst (neuron_rst[j]),
      .spike      (spike_out[j]),
      .v          (potential[j*POT_W +: POT_W])
    );
  end
endmodule

// File: tb/tb_if_neuron_layer.sv
module tb_if_neuron_layer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  int total = 0;
  int bad = 0;

  // A: main 2-neuron layer
  logic [3:0]  sin_a;
  logic [63:0] wts_a;
  logic [1:0]  nrst_a, so_a;
  logic [31:0] pot_a;
  // B: 8-bit potential, saturation
  logic [3:0]  sin_b;
  logic [31:0] wts_b;
  logic        so_b;
  logic [7:0]  pot_b;
  // C/D: closed loop with controller, REFRAC=5 and REFRAC=0
  logic [3:0]  sin_cd;
  logic [31:0] wts_c, wts_d;
  logic        so_c, so_d, nrst_c, nrst_d;
  logic [15:0] pot_c, pot_d;

  assign nrst_c = so_c;
  assign nrst_d = so_d;

  if_neuron_layer #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .REFRAC(5), .WEIGHT_W(8),
                    .POT_W(16), .THRESH(64)) dut (
    .clk(clk), .rst(rst), .step_en(en), .spike_in(sin_a), .weights(wts_a),
    .neuron_rst(nrst_a), .spike_out(so_a), .potential(pot_a));

  if_neuron_layer #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .REFRAC(5), .WEIGHT_W(8),
                    .POT_W(8), .THRESH(64)) dut_b (
    .clk(clk), .rst(rst), .step_en(en), .spike_in(sin_b), .weights(wts_b),
    .neuron_rst(1'b0), .spike_out(so_b), .potential(pot_b));

  if_neuron_layer #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .REFRAC(5), .WEIGHT_W(8),
                    .POT_W(16), .THRESH(64)) dut_c (
    .clk(clk), .rst(rst), .step_en(en), .spike_in(sin_cd), .weights(wts_c),
    .neuron_rst(nrst_c), .spike_out(so_c), .potential(pot_c));

  if_neuron_layer #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .REFRAC(0), .WEIGHT_W(8),
                    .POT_W(16), .THRESH(64)) dut_d (
    .clk(clk), .rst(rst), .step_en(en), .spike_in(sin_cd), .weights(wts_d),
    .neuron_rst(nrst_d), .spike_out(so_d), .potential(pot_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input int j, input logic [7:0] val);
    wts_a[(j*4+i)*8 +: 8] = val;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; nrst_a = 2'b00;
    sin_a = 4'($urandom); wts_a = {$urandom(), $urandom()};
    sin_b = 4'($urandom); wts_b = $urandom();
    sin_cd = 4'($urandom); wts_c = $urandom(); wts_d = $urandom();
    step(); step();
    chk("rst_spk", {30'd0, so_a}, 32'd0);
    chk("rst_pot", pot_a, 32'd0);
    chk("rst_pot_b", {24'd0, pot_b}, 32'd0);
    chk("rst_pot_cd", {pot_c, pot_d}, 32'd0);

    // integrate and fire on neuron 0
    rst = 1'b0; sin_b = '0; sin_cd = '0; wts_b = '0; wts_c = '0; wts_d = '0;
    wts_a = '0; setw(0, 0, 8'd20); sin_a = 4'b0001;
    step(); chk("if_p20", pot_a, 32'd20);
    step(); chk("if_p40", pot_a, 32'd40);
    step(); chk("if_p60", pot_a, 32'd60);
    step(); chk("if_fire", {30'd0, so_a}, 32'd1); chk("if_fire_p", pot_a, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(); chk("ref_p", pot_a, 32'd0); chk("ref_spk", {30'd0, so_a}, 32'd0);
    end
    step(); chk("ref_done", pot_a, 32'd20);

    // multi-input with a negative weight on neuron 1
    rst = 1'b1; step(); rst = 1'b0;
    wts_a = '0; setw(0, 0, 8'd20); setw(0, 1, 8'd30); setw(1, 1, 8'd40);
    setw(2, 1, 8'hF6); sin_a = 4'b0111;
    step(); chk("mi_p", pot_a, {16'd60, 16'd20});
    step(); chk("mi_fire", {30'd0, so_a}, 32'd2); chk("mi_fire_p", pot_a, {16'd0, 16'd40});

    // neuron_rst on neuron 0 (at 40)
    nrst_a = 2'b01;
    step(); chk("nr_p", pot_a, 32'd0); chk("nr_spk", {30'd0, so_a}, 32'd0);
    nrst_a = 2'b00;
    for (int k = 0; k < 5; k++) begin
      step(); chk("nr_ref_p0", {16'd0, pot_a[15:0]}, 32'd0);
    end
    chk("nr_p1_resume", {16'd0, pot_a[31:16]}, 32'd60);
    step(); chk("nr_p0_resume", pot_a, {16'd0, 16'd20});
    chk("nr_p1_fire", {30'd0, so_a}, 32'd2);
    // neuron_rst beats a threshold crossing
    nrst_a = 2'b01; setw(0, 0, 8'd100); sin_a = 4'b0001;
    step(); chk("nr_vs_fire_spk", {30'd0, so_a}, 32'd0);
    chk("nr_vs_fire_p", pot_a, 32'd0);

    // step_en gating mid-refractory (n0 r=3, n1 r=2 after two steps)
    nrst_a = 2'b00; setw(0, 0, 8'd20);
    step(); step();
    en = 1'b0; nrst_a = 2'b11; sin_a = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      step(); chk("frz_spk", {30'd0, so_a}, 32'd0); chk("frz_p", pot_a, 32'd0);
    end
    en = 1'b1; nrst_a = 2'b00; sin_a = 4'b0001;
    step(); step(); step();
    chk("res_p3", pot_a, {16'd30, 16'd0});
    step(); chk("res_p4", pot_a, {16'd60, 16'd20});
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk("hold_p", pot_a, {16'd60, 16'd20});
    end
    en = 1'b1; setw(0, 0, 8'd100);
    step(); chk("both_fire", {30'd0, so_a}, 32'd3); chk("both_fire_p", pot_a, 32'd0);
    rst = 1'b1;
    step(); chk("rst_ref_spk", {30'd0, so_a}, 32'd0); chk("rst_ref_p", pot_a, 32'd0);
    rst = 1'b0; setw(0, 0, 8'd20);
    step(); chk("rst_ref_int", pot_a, {16'd30, 16'd20});

    // saturation (B) and closed loop (C: REFRAC=5, D: REFRAC=0)
    sin_a = '0;
    sin_b = 4'b1000; wts_b = {8'h9C, 24'd0};
    sin_cd = 4'b0001; wts_c = 32'd40; wts_d = 32'd40;
    step(); chk("sat_m100", {24'd0, pot_b}, 32'h9C);
    chk("cl_p40", {pot_c, pot_d}, {16'd40, 16'd40});
    step(); chk("sat_m128", {24'd0, pot_b}, 32'h80);
    chk("cl_fire", {30'd0, so_c, so_d}, 32'd3);
    step(); chk("sat_hold", {24'd0, pot_b}, 32'h80);
    chk("cl_nrst_spk", {30'd0, so_c, so_d}, 32'd0);
    chk("cl_nrst_p", {pot_c, pot_d}, 32'd0);
    step(); chk("cl0_resume", {16'd0, pot_d}, 32'd40);
    chk("cl5_ref_p", {16'd0, pot_c}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(); chk("cl5_ref_p", {16'd0, pot_c}, 32'd0);
    end
    step(); chk("cl5_resume", {16'd0, pot_c}, 32'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
